fifo_rd_fwft_block: RTL

Read-side front end of the asynchronous FIFO, in the rd_clk domain. It synchronizes the write-domain Gray pointer into rd_clk and feeds it to the read-side empty/pointer block. It drives that block's read strobe and captures memory read data into a two-entry output buffer, presenting first-word-fall-through valid/ready data to the consumer. It also reports registered FIFO occupancy and an almost-empty flag.

---
 rtl/fifo_pkg.sv | 31 +++
 rtl/fifo_rd_fwft_block_if.sv | 18 +
 rtl/fifo_sync_block.sv | 35 +++
 rtl/fifo_rd_fwft_block.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the asynchronous FIFO read-side slice.
//   - default address/data widths
//   - output-buffer occupancy states
//   - Gray <-> binary conversion helpers (operate on up to FIFO_PTR_MAXW bits;
//     callers zero-extend narrower pointers and truncate the result)
package fifo_pkg;

  localparam int unsigned FIFO_AW_DEFAULT = 2;
  localparam int unsigned FIFO_DW_DEFAULT = 32;
  localparam int unsigned FIFO_PTR_MAXW   = 32;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  function automatic logic [FIFO_PTR_MAXW-1:0] gray2bin(input logic [FIFO_PTR_MAXW-1:0] g);
    logic [FIFO_PTR_MAXW-1:0] b;
    b[FIFO_PTR_MAXW-1] = g[FIFO_PTR_MAXW-1];
    for (int unsigned i = FIFO_PTR_MAXW - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [FIFO_PTR_MAXW-1:0] bin2gray(input logic [FIFO_PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_block_if.sv
// fifo_rd_fwft_block_if: first-word-fall-through consumer stream.
//   out_data  - head-of-queue data          (master -> slave)
//   out_valid - out_data valid              (master -> slave)
//   out_ready - consumer accepts this cycle (slave  -> master)
interface fifo_rd_fwft_block_if
  import fifo_pkg::*;
#(
  parameter int unsigned DW = FIFO_DW_DEFAULT
) ();

  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/fifo_sync_block.sv
// fifo_sync_block: STAGES-deep flop chain bringing a multi-bit Gray-coded
// value into the clk domain. Only safe for values that change by at most one
// bit per update.
//   clk   - destination clock
//   reset - asynchronous, active-high; clears every stage
//   d_i   - asynchronous input
//   q_o   - synchronized output (last stage)
module fifo_sync_block #(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= d_i;
      for (int unsigned i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_fwft_block.sv
// fifo_rd_fwft_block: read-side front end of the asynchronous FIFO (rd_clk).
// Synchronizes the write Gray pointer, drives the read strobe of the empty
// block, and holds up to two memory words in a FWFT output buffer.
// Optional build macro FIFO_RD_LEVEL_EN enables registered occupancy
// (rd_count) and almost-empty reporting; without it rd_count is 0 and
// rd_almost_empty follows rd_fifo_empty.
// Ports:
//   rd_clk, reset       - read clock, asynchronous active-high reset
//   wr_gray_pointer     - write Gray pointer (asynchronous)
//   rd_wr_gray_pointer  - synchronized write Gray pointer to the empty block
//   rd_gray_pointer     - read Gray pointer from the empty block
//   rd_fifo_empty       - registered empty flag from the empty block
//   rd_read             - read strobe to the empty block
//   mem_rd_data         - combinational RAM data at the current read address
//   out_if              - FWFT consumer stream (out_data/out_valid/out_ready)
//   rd_count            - memory occupancy 0..2^AW (buffered words excluded)
//   rd_almost_empty     - rd_count <= AE_LEVEL
module fifo_rd_fwft_block
  import fifo_pkg::*;
#(
  parameter int unsigned AW          = FIFO_AW_DEFAULT,
  parameter int unsigned DW          = FIFO_DW_DEFAULT,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AE_LEVEL    = 1
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  input  logic [AW:0]          wr_gray_pointer,
  output logic [AW:0]          rd_wr_gray_pointer,
  input  logic [AW:0]          rd_gray_pointer,
  input  logic                 rd_fifo_empty,
  output logic                 rd_read,
  input  logic [DW-1:0]        mem_rd_data,
  fifo_rd_fwft_block_if.master out_if,
  output logic [AW:0]          rd_count,
  output logic                 rd_almost_empty
);

  localparam int unsigned PW = AW + 1;

  fifo_sync_block #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wr_ptr_sync (
    .clk   (rd_clk),
    .reset (reset),
    .d_i   (wr_gray_pointer),
    .q_o   (rd_wr_gray_pointer)
  );

  // Output buffer: buf0 is the head, buf1 the skid entry.
  buf_state_e    state_q, state_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;
  logic          pop;

  // Registered-only terms: no path from out_ready to rd_read.
  assign rd_read = !rd_fifo_empty && (state_q != BUF_TWO);
  assign pop     = (state_q != BUF_EMPTY) && out_if.out_ready;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q <= BUF_EMPTY;
      buf0_q  <= '0;
      buf1_q  <= '0;
    end else begin
      state_q <= state_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
    end
  end

  // Incoming word lands in the lowest entry that is free after the pop.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (rd_read) begin
          buf0_d  = mem_rd_data;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (pop && rd_read) begin
          buf0_d = mem_rd_data;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end else if (rd_read) begin
          buf1_d  = mem_rd_data;
          state_d = BUF_TWO;
        end
      end
      BUF_TWO: begin
        // rd_read is low here, so a pop never coincides with a push.
        if (pop) begin
          buf0_d  = buf1_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  assign out_if.out_valid = (state_q != BUF_EMPTY);
  assign out_if.out_data  = buf0_q;

`ifdef FIFO_RD_LEVEL_EN
  logic [AW:0] wr_bin, rd_bin, count_next;
  logic [AW:0] rd_count_q;
  logic        almost_empty_q;

  assign wr_bin     = PW'(gray2bin(FIFO_PTR_MAXW'(rd_wr_gray_pointer)));
  assign rd_bin     = PW'(gray2bin(FIFO_PTR_MAXW'(rd_gray_pointer)));
  // Modulo 2^(AW+1) difference; correct across pointer wrap.
  assign count_next = wr_bin - rd_bin;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      rd_count_q     <= '0;
      almost_empty_q <= 1'b1;
    end else begin
      rd_count_q     <= count_next;
      almost_empty_q <= (FIFO_PTR_MAXW'(count_next) <= AE_LEVEL);
    end
  end

  assign rd_count        = rd_count_q;
  assign rd_almost_empty = almost_empty_q;
`else
  logic rd_gray_unused;
  localparam int unsigned ae_level_unused = AE_LEVEL;

  assign rd_gray_unused  = ^rd_gray_pointer;
  assign rd_count        = '0;
  assign rd_almost_empty = rd_fifo_empty;
`endif

endmodule
